// File: rtl/cp0_fwd_pipe_pkg.sv
// Shared CP0 definitions for the write-tracking pipeline: register addresses,
// bus widths and the in-flight write entry.
package cp0_fwd_pipe_pkg;

   localparam int unsigned CP0_ADDR_W = 8;
   localparam int unsigned CP0_DATA_W = 32;

   // {reg, sel} encoding: Status=12/0, Cause=13/0, EPC=14/0
   localparam logic [CP0_ADDR_W-1:0] CP0_REG_STATUS = 8'h60;
   localparam logic [CP0_ADDR_W-1:0] CP0_REG_CAUSE  = 8'h68;
   localparam logic [CP0_ADDR_W-1:0] CP0_REG_EPC    = 8'h70;

   typedef struct packed {
      logic                  v;
      logic [CP0_ADDR_W-1:0] addr;
      logic [CP0_DATA_W-1:0] data;
   } cp0_wr_t;

endpackage

// File: rtl/cp0_fwd_match.sv
// Youngest-first priority match of one CP0 address against the in-flight
// write entries; entry 0 is the youngest. Falls back to the raw value.
module cp0_fwd_match #(
   parameter int unsigned DEPTH  = 2,
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DATA_W = 32
) (
   input  logic [DEPTH-1:0]             v,
   input  logic [DEPTH-1:0][ADDR_W-1:0] addr,
   input  logic [DEPTH-1:0][DATA_W-1:0] data,
   input  logic [ADDR_W-1:0]            rd_addr,
   input  logic [DATA_W-1:0]            raw,
   output logic [DATA_W-1:0]            fwd_c
);

   // Scan oldest to youngest so the youngest matching entry is written last.
   always_comb begin
      fwd_c = raw;
      for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
         if (v[k] && (addr[k] == rd_addr)) begin
            fwd_c = data[k];
         end
      end
   end

endmodule

// File: rtl/cp0_fwd_pipe.sv
// In-flight CP0 write pipeline: shifts mtc0 writes under stall/flush, commits
// the oldest entry to CP0 and forwards pending writes to read/snapshot ports.
module cp0_fwd_pipe
   import cp0_fwd_pipe_pkg::*;
#(
   parameter int unsigned DATA_W       = CP0_DATA_W,
   parameter int unsigned ADDR_W       = CP0_ADDR_W,
   parameter int unsigned DEPTH        = 2,
   parameter int unsigned NUM_RD       = 1,
   parameter bit          SNAP_FWD_ALL = 1'b0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       stall,
   input  logic                       flush,
   input  logic                       wr_en_i,
   input  logic [ADDR_W-1:0]          wr_addr_i,
   input  logic [DATA_W-1:0]          wr_data_i,
   output logic                       commit_en_o,
   output logic [ADDR_W-1:0]          commit_addr_o,
   output logic [DATA_W-1:0]          commit_data_o,
   input  logic [NUM_RD*ADDR_W-1:0]   rd_addr_i,
   input  logic [NUM_RD*DATA_W-1:0]   cp0_rd_data_i,
   output logic [NUM_RD*DATA_W-1:0]   rd_data_o,
   input  logic [DATA_W-1:0]          cp0_status_i,
   input  logic [DATA_W-1:0]          cp0_cause_i,
   input  logic [DATA_W-1:0]          cp0_epc_i,
   output logic [DATA_W-1:0]          cp0_status_o,
   output logic [DATA_W-1:0]          cp0_cause_o,
   output logic [DATA_W-1:0]          cp0_epc_o,
   output logic [$clog2(DEPTH+1)-1:0] pending_o
);

   localparam int unsigned   CNT_W    = $clog2(DEPTH + 1);
   localparam logic [DEPTH-1:0] OLD_MASK = DEPTH'(1) << (DEPTH - 1);

   logic [DEPTH-1:0]             v_q,    v_d;
   logic [DEPTH-1:0][ADDR_W-1:0] addr_q, addr_d;
   logic [DEPTH-1:0][DATA_W-1:0] data_q, data_d;
   logic [CNT_W-1:0]             cnt_d;
   logic [DEPTH-1:0]             snap_v;

   // Next entry state; flush under stall spares only the oldest entry.
   always_comb begin
      v_d    = v_q;
      addr_d = addr_q;
      data_d = data_q;
      cnt_d  = '0;
      if (!stall) begin
         for (int k = 1; k < int'(DEPTH); k++) begin
            v_d[k]    = v_q[k-1];
            addr_d[k] = addr_q[k-1];
            data_d[k] = data_q[k-1];
         end
         v_d[0]    = wr_en_i;
         addr_d[0] = wr_addr_i;
         data_d[0] = wr_data_i;
         if (flush) begin
            v_d = '0;
         end
      end else if (flush) begin
         v_d = v_q & OLD_MASK;
      end
      for (int k = 0; k < int'(DEPTH); k++) begin
         cnt_d = cnt_d + CNT_W'(v_d[k]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v_q       <= '0;
         addr_q    <= '0;
         data_q    <= '0;
         pending_o <= '0;
      end else begin
         v_q       <= v_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
         pending_o <= cnt_d;
      end
   end

   assign commit_en_o   = v_q[DEPTH-1] && !stall;
   assign commit_addr_o = addr_q[DEPTH-1];
   assign commit_data_o = data_q[DEPTH-1];

   for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
      cp0_fwd_match #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_rd (
         .v       (v_q),
         .addr    (addr_q),
         .data    (data_q),
         .rd_addr (rd_addr_i[i*ADDR_W +: ADDR_W]),
         .raw     (cp0_rd_data_i[i*DATA_W +: DATA_W]),
         .fwd_c   (rd_data_o[i*DATA_W +: DATA_W])
      );
   end

   // Exception views see either every entry or only the one about to commit.
   assign snap_v = SNAP_FWD_ALL ? v_q : (v_q & OLD_MASK);

   cp0_fwd_match #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_status (
      .v       (snap_v),
      .addr    (addr_q),
      .data    (data_q),
      .rd_addr (ADDR_W'(CP0_REG_STATUS)),
      .raw     (cp0_status_i),
      .fwd_c   (cp0_status_o)
   );

   cp0_fwd_match #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_cause (
      .v       (snap_v),
      .addr    (addr_q),
      .data    (data_q),
      .rd_addr (ADDR_W'(CP0_REG_CAUSE)),
      .raw     (cp0_cause_i),
      .fwd_c   (cp0_cause_o)
   );

   cp0_fwd_match #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_epc (
      .v       (snap_v),
      .addr    (addr_q),
      .data    (data_q),
      .rd_addr (ADDR_W'(CP0_REG_EPC)),
      .raw     (cp0_epc_i),
      .fwd_c   (cp0_epc_o)
   );

endmodule

// File: tb/tb_cp0_fwd_pipe.sv
// Bench for cp0_fwd_pipe: DUT a (DEPTH=2, oldest-only views) and DUT b
// (DEPTH=3, all-entry views, two read ports); commits go through scoreboards.
module tb_cp0_fwd_pipe;
   import cp0_fwd_pipe_pkg::*;

   logic clk, rst;

   logic        a_stall, a_flush, a_wr_en, a_commit_en;
   logic [7:0]  a_wr_addr, a_commit_addr, a_rd_addr;
   logic [31:0] a_wr_data, a_commit_data, a_cp0_rd, a_rd_data;
   logic [31:0] a_status_i, a_cause_i, a_epc_i, a_status_o, a_cause_o, a_epc_o;
   logic [1:0]  a_pending;

   logic        b_stall, b_flush, b_wr_en, b_commit_en;
   logic [7:0]  b_wr_addr, b_commit_addr;
   logic [15:0] b_rd_addr;
   logic [31:0] b_wr_data, b_commit_data;
   logic [63:0] b_cp0_rd, b_rd_data;
   logic [31:0] b_status_i, b_cause_i, b_epc_i, b_status_o, b_cause_o, b_epc_o;
   logic [1:0]  b_pending;

   int n_run  = 0;
   int n_fail = 0;
   cp0_wr_t qa[$];
   cp0_wr_t qb[$];
   cp0_wr_t ea, eb;

   cp0_fwd_pipe #(.DEPTH(2), .NUM_RD(1), .SNAP_FWD_ALL(1'b0)) dut_a (
      .clk(clk), .rst(rst), .stall(a_stall), .flush(a_flush),
      .wr_en_i(a_wr_en), .wr_addr_i(a_wr_addr), .wr_data_i(a_wr_data),
      .commit_en_o(a_commit_en), .commit_addr_o(a_commit_addr), .commit_data_o(a_commit_data),
      .rd_addr_i(a_rd_addr), .cp0_rd_data_i(a_cp0_rd), .rd_data_o(a_rd_data),
      .cp0_status_i(a_status_i), .cp0_cause_i(a_cause_i), .cp0_epc_i(a_epc_i),
      .cp0_status_o(a_status_o), .cp0_cause_o(a_cause_o), .cp0_epc_o(a_epc_o),
      .pending_o(a_pending)
   );

   cp0_fwd_pipe #(.DEPTH(3), .NUM_RD(2), .SNAP_FWD_ALL(1'b1)) dut_b (
      .clk(clk), .rst(rst), .stall(b_stall), .flush(b_flush),
      .wr_en_i(b_wr_en), .wr_addr_i(b_wr_addr), .wr_data_i(b_wr_data),
      .commit_en_o(b_commit_en), .commit_addr_o(b_commit_addr), .commit_data_o(b_commit_data),
      .rd_addr_i(b_rd_addr), .cp0_rd_data_i(b_cp0_rd), .rd_data_o(b_rd_data),
      .cp0_status_i(b_status_i), .cp0_cause_i(b_cause_i), .cp0_epc_i(b_epc_i),
      .cp0_status_o(b_status_o), .cp0_cause_o(b_cause_o), .cp0_epc_o(b_epc_o),
      .pending_o(b_pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr_a(input logic [7:0] ad, input logic [31:0] d, input bit expect_commit);
      a_wr_en = 1'b1; a_wr_addr = ad; a_wr_data = d;
      if (expect_commit) qa.push_back(cp0_wr_t'{v: 1'b1, addr: ad, data: d});
   endtask

   task automatic wr_b(input logic [7:0] ad, input logic [31:0] d, input bit expect_commit);
      b_wr_en = 1'b1; b_wr_addr = ad; b_wr_data = d;
      if (expect_commit) qb.push_back(cp0_wr_t'{v: 1'b1, addr: ad, data: d});
   endtask

   // Scoreboard monitor: every commit strobe must match the next expected write.
   always @(negedge clk) begin
      if (rst === 1'b0) begin
         if (a_commit_en === 1'b1) begin
            if (qa.size() == 0) begin
               n_run++; n_fail++;
               $display("FAIL a_commit_unexpected: got addr %h data %h expected none", a_commit_addr, a_commit_data);
            end else begin
               ea = qa.pop_front();
               chk("a_commit_addr", 32'(a_commit_addr), 32'(ea.addr));
               chk("a_commit_data", a_commit_data, ea.data);
            end
         end
         if (b_commit_en === 1'b1) begin
            if (qb.size() == 0) begin
               n_run++; n_fail++;
               $display("FAIL b_commit_unexpected: got addr %h data %h expected none", b_commit_addr, b_commit_data);
            end else begin
               eb = qb.pop_front();
               chk("b_commit_addr", 32'(b_commit_addr), 32'(eb.addr));
               chk("b_commit_data", b_commit_data, eb.data);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      a_stall = 0; a_flush = 0; a_wr_en = 0; a_wr_addr = '0; a_wr_data = '0;
      a_rd_addr = CP0_REG_CAUSE; a_cp0_rd = '0;
      a_status_i = 32'h0000_1234; a_cause_i = 32'h0000_5678; a_epc_i = 32'h0;
      b_stall = 0; b_flush = 0; b_wr_en = 0; b_wr_addr = '0; b_wr_data = '0;
      b_rd_addr = {CP0_REG_STATUS, CP0_REG_EPC}; b_cp0_rd = {32'h0000_1111, 32'h0000_2222};
      b_status_i = 32'h0; b_cause_i = 32'h0000_00C0; b_epc_i = 32'h0000_00E0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_pending_a", 32'(a_pending), 32'd0);
      chk("rst_commit_a", 32'(a_commit_en), 32'd0);
      chk("rst_pending_b", 32'(b_pending), 32'd0);
      tick();

      // Basic path: commit exactly two cycles after issue
      wr_a(CP0_REG_STATUS, 32'h0000_FF01, 1'b1);
      @(negedge clk); chk("basic_c0_commit", 32'(a_commit_en), 32'd0);
      tick(); a_wr_en = 1'b0;
      @(negedge clk); chk("basic_c1_commit", 32'(a_commit_en), 32'd0);
      chk("basic_c1_pending", 32'(a_pending), 32'd1);
      tick();
      @(negedge clk); chk("basic_c2_commit", 32'(a_commit_en), 32'd1);
      chk("basic_c2_pending", 32'(a_pending), 32'd1);
      chk("basic_c2_status_view", a_status_o, 32'h0000_FF01);
      tick();
      @(negedge clk); chk("basic_c3_commit", 32'(a_commit_en), 32'd0);
      chk("basic_c3_pending", 32'(a_pending), 32'd0);
      tick();

      // Forward priority: youngest write to Cause wins
      wr_a(CP0_REG_CAUSE, 32'h11, 1'b1);
      @(negedge clk); chk("fwd_c0_rd", a_rd_data, 32'h0);
      tick(); wr_a(CP0_REG_CAUSE, 32'h22, 1'b1);
      @(negedge clk); chk("fwd_c1_rd", a_rd_data, 32'h11);
      tick(); a_wr_en = 1'b0;
      @(negedge clk); chk("fwd_c2_rd", a_rd_data, 32'h22);
      chk("fwd_c2_commit", 32'(a_commit_en), 32'd1);
      tick();
      @(negedge clk); chk("fwd_c3_rd", a_rd_data, 32'h22);
      tick(); a_cp0_rd = 32'h33;
      @(negedge clk); chk("fwd_c4_rd_raw", a_rd_data, 32'h33);
      chk("fwd_c4_pending", 32'(a_pending), 32'd0);
      tick();

      // Flush: older EPC commits, younger Status is killed
      a_status_i = 32'hAAAA_0000;
      wr_a(CP0_REG_EPC, 32'hBFC0_0380, 1'b1);
      tick(); wr_a(CP0_REG_STATUS, 32'h1, 1'b0);
      tick(); a_wr_en = 1'b0; a_flush = 1'b1;
      @(negedge clk); chk("flush_commit", 32'(a_commit_en), 32'd1);
      chk("flush_pending_pre", 32'(a_pending), 32'd2);
      chk("snap0_status_young_only", a_status_o, 32'hAAAA_0000);
      chk("snap0_epc_oldest", a_epc_o, 32'hBFC0_0380);
      tick(); a_flush = 1'b0;
      @(negedge clk); chk("flush_pending_post", 32'(a_pending), 32'd0);
      chk("flush_c3_commit", 32'(a_commit_en), 32'd0);
      tick();
      @(negedge clk); chk("flush_c4_commit", 32'(a_commit_en), 32'd0);
      tick();

      // Reset mid-operation overrides stall
      wr_a(CP0_REG_CAUSE, 32'h5, 1'b0);
      tick(); wr_a(CP0_REG_CAUSE, 32'h6, 1'b0);
      tick(); a_wr_en = 1'b0; a_stall = 1'b1; rst = 1'b1;
      @(negedge clk); chk("rstmid_pending_pre", 32'(a_pending), 32'd2);
      chk("rstmid_commit_stall", 32'(a_commit_en), 32'd0);
      tick(); rst = 1'b0; a_stall = 1'b0;
      @(negedge clk); chk("rstmid_pending_post", 32'(a_pending), 32'd0);
      chk("rstmid_commit0", 32'(a_commit_en), 32'd0);
      tick();
      @(negedge clk); chk("rstmid_commit1", 32'(a_commit_en), 32'd0);
      tick();
      wr_a(CP0_REG_STATUS, 32'h7, 1'b1);
      tick(); a_wr_en = 1'b0;
      @(negedge clk); chk("rstmid_new_c1", 32'(a_commit_en), 32'd0);
      tick();
      @(negedge clk); chk("rstmid_new_c2", 32'(a_commit_en), 32'd1);
      tick();

      // DUT b: all-entry snapshot views, then stall+flush on a full pipe
      wr_b(CP0_REG_STATUS, 32'h3C, 1'b1);
      tick(); wr_b(CP0_REG_EPC, 32'h100, 1'b0);
      @(negedge clk); chk("snap1_status_imm", b_status_o, 32'h3C);
      chk("b_rd1_status", b_rd_data[63:32], 32'h3C);
      chk("b_rd0_raw", b_rd_data[31:0], 32'h2222);
      tick(); wr_b(CP0_REG_CAUSE, 32'h200, 1'b0);
      tick(); wr_b(CP0_REG_STATUS, 32'hDEAD, 1'b0); b_stall = 1'b1; b_flush = 1'b1;
      @(negedge clk); chk("sf_c3_commit", 32'(b_commit_en), 32'd0);
      chk("sf_c3_pending", 32'(b_pending), 32'd3);
      chk("snap1_cause", b_cause_o, 32'h200);
      chk("snap1_epc", b_epc_o, 32'h100);
      chk("b_rd0_epc", b_rd_data[31:0], 32'h100);
      tick(); b_flush = 1'b0; b_wr_en = 1'b0;
      @(negedge clk); chk("sf_c4_commit", 32'(b_commit_en), 32'd0);
      chk("sf_c4_pending", 32'(b_pending), 32'd1);
      chk("sf_c4_epc_raw", b_epc_o, 32'hE0);
      tick();
      @(negedge clk); chk("sf_c5_commit", 32'(b_commit_en), 32'd0);
      tick(); b_stall = 1'b0;
      @(negedge clk); chk("sf_c6_commit", 32'(b_commit_en), 32'd1);
      chk("sf_c6_pending", 32'(b_pending), 32'd1);
      tick();
      @(negedge clk); chk("sf_c7_commit", 32'(b_commit_en), 32'd0);
      chk("sf_c7_pending", 32'(b_pending), 32'd0);
      chk("sf_c7_status_raw", b_status_o, 32'h0);
      tick();

      chk("qa_drained", 32'(qa.size()), 32'd0);
      chk("qb_drained", 32'(qb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule

// File: doc/cp0_fwd_pipe.md
Name: cp0_fwd_pipe

Overview:
- Parametrised CP0 write-tracking and forwarding block. It replaces fixed two-source (MEM/WB) forwarding with a DEPTH-entry in-flight write pipeline.
- Captures mtc0 writes issued upstream and shifts them with the pipeline under stall/flush control. The oldest entry is presented to CP0 as the commit write.
- Serves NUM_RD forwarded CP0 read ports plus forwarded Status/Cause/EPC views for exception logic.
- Sits between EX/MEM control and the CP0 register file.

Parameters:
- DATA_W, 32, CP0 data width.
- ADDR_W, 8, CP0 register address width (same encoding as cp0def CP0 address bus).
- DEPTH, 2, in-flight write stages; legal range 1..4.
- NUM_RD, 1, number of independent forwarded read ports; legal range 1..2.
- SNAP_FWD_ALL, 0:
  - 0: Status/Cause/EPC views forward from the oldest entry only.
  - 1: those views forward from any entry, youngest-first.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- stall  in  1  hold all entries; suppress commit
- flush  in  1  kill entries 0..DEPTH-2
- wr_en_i  in  1  new CP0 write from upstream
- wr_addr_i  in  ADDR_W  write address
- wr_data_i  in  DATA_W  write data
- commit_en_o  out  1  write strobe to CP0
- commit_addr_o  out  ADDR_W  commit address
- commit_data_o  out  DATA_W  commit data
- rd_addr_i  in  NUM_RD*ADDR_W  packed read addresses, port i at [i*ADDR_W +: ADDR_W]
- cp0_rd_data_i  in  NUM_RD*DATA_W  raw CP0 read data per port
- rd_data_o  out  NUM_RD*DATA_W  forwarded read data per port
- cp0_status_i / cp0_cause_i / cp0_epc_i  in  DATA_W each  raw CP0 registers
- cp0_status_o / cp0_cause_o / cp0_epc_o  out  DATA_W each  forwarded views
- pending_o  out  $clog2(DEPTH+1)  count of valid entries

Behaviour:
- Storage:
  - Entries e[0..DEPTH-1], each holding {v, addr, data}.
  - e[0] is youngest; e[DEPTH-1] is oldest.
- Reset (clk edge with rst=1):
  - All v <= 0; addr/data <= 0.
  - pending_o <= 0.
  - commit_en_o is 0 during and after reset until a write reaches e[DEPTH-1].
  - rst overrides stall and flush.
- Normal cycle (stall=0, flush=0):
  - e[k] <= e[k-1] for k >= 1.
  - e[0] <= {wr_en_i, wr_addr_i, wr_data_i}.
  - The entry in e[DEPTH-1] before the edge is consumed by commit.
- Commit (combinational):
  - commit_en_o = e[DEPTH-1].v && !stall.
  - commit_addr_o / commit_data_o = e[DEPTH-1].addr / .data.
  - Latency from wr_en_i sampled to commit_en_o high = DEPTH cycles, with no stalls.
- Stall=1, flush=0:
  - All entries hold; wr_* is ignored.
  - commit_en_o = 0.
- Flush=1, stall=0:
  - e[DEPTH-1] commits in this cycle (it is older than the faulting instruction).
  - At the edge, e[0..DEPTH-1] all become invalid, including the shift-in from wr_*.
- Flush=1, stall=1:
  - e[0..DEPTH-2].v <= 0.
  - e[DEPTH-1] holds and commits after the stall releases.
  - flush wins over stall for every entry except the oldest.
- DEPTH=1:
  - flush has no entry to kill.
  - The in-flight write still commits when stall=0.
- Read forwarding, per port i (combinational):
  - Matching scans e[0] first, then e[1..DEPTH-1].
  - The first valid entry with addr == rd_addr_i[i] supplies the data.
  - With no match, rd_data_o[i] = cp0_rd_data_i[i].
  - Two valid entries to the same address: the youngest wins.
- Snapshot views:
  - Status, Cause and EPC use the cp0def constants for their addresses.
  - SNAP_FWD_ALL=0: a view forwards only when e[DEPTH-1] is valid and its addr matches.
  - SNAP_FWD_ALL=1: views use the same youngest-first scan as the read ports.
  - With no match, the raw *_i value passes through.
- pending_o:
  - Registered population count of v after each update.
  - Never exceeds DEPTH.
- No write is dropped or duplicated across any stall/flush sequence, except writes killed by flush.

Decomposition:
- Shared package (cp0def include):
  - CP0_REG_STATUS / CAUSE / EPC address constants.
  - CP0 address and data bus widths.
  - Entry struct {v, addr, data}.
- One sub-module, cp0_fwd_match:
  - Combinational youngest-first priority match over DEPTH entries for one address.
  - Instantiated NUM_RD+3 times: once per read port, plus Status, Cause and EPC.

Test Plan:
- Basic path, DEPTH=2: wr_en_i=1, addr=CP0_REG_STATUS, data=0x0000FF01 at cycle 0, stall=0.
  - commit_en_o=1 with that addr/data at cycle 2 only.
  - pending_o = 1, 1, 0.
- Forward priority: back-to-back writes Cause=0x11 then Cause=0x22; read rd_addr_i=CP0_REG_CAUSE, cp0_rd_data_i=0x0.
  - rd_data_o = 0x11 for one cycle, then 0x22.
  - After both commit, rd_data_o equals the raw input.
- Flush: writes EPC=0xBFC00380 (older) then Status=0x1 (younger); pulse flush while the EPC write is in e[1].
  - EPC commits in that cycle.
  - The Status write never commits; pending_o = 0 next cycle.
- Stall + flush, DEPTH=3: pipeline full; stall=1 and flush=1 for one cycle, then stall held 2 more cycles.
  - commit_en_o = 0 throughout the stall.
  - Oldest entry commits on the first unstalled cycle; e[0..1] are lost.
- Snapshot mode:
  - SNAP_FWD_ALL=0: Status write in e[0] leaves cp0_status_o = cp0_status_i.
  - SNAP_FWD_ALL=1: the same write appears on cp0_status_o immediately.
- Reset mid-operation: rst=1 with 2 valid entries and stall=1.
  - Next cycle all v=0 and pending_o = 0.
  - commit_en_o stays 0 until a new write reaches the oldest stage.
